serv_bus_sched: RTL

// Shares one Wishbone master port between the core's instruction bus (ibus) and data bus (dbus).

---
 rtl/serv_bus_sched.sv | 136 +++++++++++++
 1 files changed

// File: rtl/serv_bus_sched.sv
// Shares one Wishbone master port between the core's ibus and dbus.
// One requester is granted at a time. Responses are registered, and a watchdog ends hung cycles.
module serv_bus_sched #(
   parameter bit          ARB_MODE  = 1'b0,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_timeout
);

   // state | meaning
   // IDLE  | no grant, arbitrate sampled cyc inputs
   // GNT_I | ibus owns the shared port
   // GNT_D | dbus owns the shared port
   // RESP  | ack pulse cycle, port idle, lets the master drop cyc
   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

   // Compare one below terminal count: the count reaches 2**W-1 on the edge that aborts.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t               state, state_nxt;
   logic [TIMEOUT_W-1:0] wdog;
   logic                 last_d;
   logic                 load_i, load_d;
   logic                 cap_i, cap_d;
   logic                 to_i, to_d;
   logic                 in_gnt, stay_gnt;

   always_comb begin
      state_nxt = state;
      load_i    = 1'b0;
      load_d    = 1'b0;
      cap_i     = 1'b0;
      cap_d     = 1'b0;
      to_i      = 1'b0;
      to_d      = 1'b0;
      case (state)
         IDLE: begin
            if (i_dbus_cyc && (!i_ibus_cyc || !ARB_MODE || !last_d)) begin
               state_nxt = GNT_D;
               load_d    = 1'b1;
            end else if (i_ibus_cyc) begin
               state_nxt = GNT_I;
               load_i    = 1'b1;
            end
         end
         GNT_I: begin
            if (!i_ibus_cyc) begin
               state_nxt = IDLE;
            end else if (i_wb_ack) begin
               state_nxt = RESP;
               cap_i     = 1'b1;
            end else if (wdog == WD_LAST) begin
               state_nxt = RESP;
               to_i      = 1'b1;
            end
         end
         GNT_D: begin
            if (!i_dbus_cyc) begin
               state_nxt = IDLE;
            end else if (i_wb_ack) begin
               state_nxt = RESP;
               cap_d     = 1'b1;
            end else if (wdog == WD_LAST) begin
               state_nxt = RESP;
               to_d      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_gnt   = (state == GNT_I) || (state == GNT_D);
   assign stay_gnt = in_gnt && ((state_nxt == GNT_I) || (state_nxt == GNT_D));
   assign o_wb_cyc = in_gnt;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state      <= IDLE;
         wdog       <= '0;
         last_d     <= 1'b0;
         o_ibus_ack <= 1'b0;
         o_dbus_ack <= 1'b0;
         o_timeout  <= 1'b0;
         o_ibus_rdt <= '0;
         o_dbus_rdt <= '0;
         o_wb_adr   <= '0;
         o_wb_dat   <= '0;
         o_wb_sel   <= '0;
         o_wb_we    <= 1'b0;
      end else begin
         state      <= state_nxt;
         wdog       <= stay_gnt ? wdog + 1'b1 : '0;
         o_ibus_ack <= cap_i | to_i;
         o_dbus_ack <= cap_d | to_d;
         o_timeout  <= to_i | to_d;
         if (cap_i) o_ibus_rdt <= i_wb_rdt;
         if (to_i)  o_ibus_rdt <= '0;
         if (cap_d) o_dbus_rdt <= i_wb_rdt;
         if (to_d)  o_dbus_rdt <= '0;
         if (load_d) begin
            last_d   <= 1'b1;
            o_wb_adr <= i_dbus_adr;
            o_wb_dat <= i_dbus_dat;
            o_wb_sel <= i_dbus_sel;
            o_wb_we  <= i_dbus_we;
         end else if (load_i) begin
            last_d   <= 1'b0;
            o_wb_adr <= i_ibus_adr;
            o_wb_dat <= '0;
            o_wb_sel <= 4'hf;
            o_wb_we  <= 1'b0;
         end
      end
   end

endmodule
